tia_horizontal_timebase: RTL and testbench
==========================================

# tia_horizontal_timebase

Horizontal timebase of the TIA video block. Divides the color clock by four into two non-overlapping phases, `hphi1` and `hphi2`. It also runs the 6-bit horizontal-sync LFSR, which repeats every 57 H-cycles (228 color clocks = one scan line). The downstream horizontal decode logic consumes `out`, `shb` and the phase strobes.

## Interface
- No parameters. Constants are fixed in the package.
- `clk`  in  1  color clock.
- `rsyn`  in  1  asynchronous, active-high reset.
- `hphi1`  out  1  phase-1 strobe: high 1 clk of every 4; decode/sample phase.
- `hphi2`  out  1  phase-2 strobe: high 1 clk of every 4, two clks after `hphi1`; shift phase.
- `rsynl`  out  1  latched reset: high from reset until the first `hphi1`.
- `out`  out  6  LFSR state, `out[5]` is MSB.
- `shb`  out  1  shift-reset decode: the next shift loads 000000.
- `rsynd`  out  1  delayed reset: high from reset until the first `hphi2`.

## Operation
- Phase counter `p` counts 0..3 and wraps. Its reset value is 3.
  - `hphi1` is registered and equals (p==0).
  - `hphi2` is registered and equals (p==2).
  - The two strobes never overlap. Each has a 25% duty cycle.
- LFSR next state: {out[4:0], ~(out[5]^out[4])}.
- Sequence from 000000: 000001, 000011, 000111, 001111, 011111, 111110, …
- Index 56 is the terminal state 001010. The LFSR never visits all-ones or repeats a state within a period.
- `shb` = (out == 001010) | `rsynl`. It is combinational.
- Shift: on the clk edge where p goes 2→3 (i.e. `hphi2` high), `out` <= `shb` ? 000000 : next state.
- `rsynl` is cleared on the clk edge that enters p==0 (the first `hphi1`).
- `rsynd` is cleared on the clk edge that enters p==2 (the first `hphi2`).
- Both `rsynl` and `rsynd` are set asynchronously by `rsyn`.
- Reset values: `hphi1`=0, `hphi2`=0, `out`=000000, `rsynl`=1, `rsynd`=1, `shb`=1, p=3.

## Timing
- Clk edge 1 after reset release: `hphi1` rises, `rsynl` falls, `out`=000000 (H-index 0).
- Edge 3: `hphi2` rises, `rsynd` falls.
- Edge 4: `out` takes the next state (000001). Edge 5: next `hphi1`.
- At the k-th `hphi1` (k from 0), `out` = state index k mod 57. `out`==0 only when k ≡ 0 mod 57.
- Latency from terminal decode to 000000 is one shift (4 clks).
- `rsyn` asserted mid-line:
  - Immediate asynchronous return to reset values, including strobes dropping mid-pulse.
  - The sequence restarts at index 0 on release.
- `rsyn` held high freezes all outputs at their reset values.

## Configuration
- `TIA_HTIMEBASE_ASSERT_EN` defined: simulation assertions are compiled in.
  - `hphi1` & `hphi2` is never true.
  - `out` is never 111111.
  - `out` returns to 000000 exactly 57 shifts after leaving it.
- Not defined: no assertions. RTL behaviour is identical.

## Structure
- Package `tia_pkg`: `HLFSR_W`=6, `HLFSR_RESET`=6'b000000, `HLFSR_TERMINAL`=6'b001010, `HLFSR_PERIOD`=57, `PHASE_DIV`=4.
- Sub-module `tia_biphase_clock` holds p, `hphi1`, `hphi2` and `rsynl`.
- The top level holds the LFSR, the `shb` decode and `rsynd`.

## Test plan
- Reset, then release and run: `out`==000000 at `hphi1` #0, #57 and #114; `out`!=0 at every other `hphi1`.
- Sequence check: at `hphi1` #1..#6, `out` = 000001, 000011, 000111, 001111, 011111, 111110; at #56, `out` = 001010 with `shb`=1.
- Phase check over 40 clks: `hphi1`/`hphi2` each high 1 of 4 clks, offset by 2 clks, never simultaneous.
- Reset release: `rsynl` falls on edge 1, `rsynd` falls on edge 3, `shb` low at `hphi1` #1.
- Assert `rsyn` at `hphi1` #30 mid-pulse: outputs return to reset values immediately. After release, `out`==000000 at the next `hphi1` and the period restarts (zero again 57 `hphi1`s later).
- With `TIA_HTIMEBASE_ASSERT_EN` defined, run 3 periods: no assertion fires.

Source files
------------

// File: rtl/tia_pkg.sv
// Shared constants and the LFSR step function for the TIA horizontal timebase.
package tia_pkg;

  localparam int unsigned HLFSR_W = 6;
  localparam logic [HLFSR_W-1:0] HLFSR_RESET    = 6'b000000;
  localparam logic [HLFSR_W-1:0] HLFSR_TERMINAL = 6'b001010;
  localparam int unsigned HLFSR_PERIOD = 57;

  localparam int unsigned PHASE_DIV = 4;
  localparam int unsigned PHASE_W   = $clog2(PHASE_DIV);

  // Phase counter encodings: reset sits on the last phase so the first edge enters phi1.
  localparam logic [PHASE_W-1:0] PHASE_RESET = PHASE_W'(PHASE_DIV - 1);
  localparam logic [PHASE_W-1:0] PHASE_PHI1  = '0;
  localparam logic [PHASE_W-1:0] PHASE_PHI2  = PHASE_W'(PHASE_DIV / 2);

  function automatic logic [HLFSR_W-1:0] hlfsr_next(input logic [HLFSR_W-1:0] s);
    return {s[HLFSR_W-2:0], ~(s[HLFSR_W-1] ^ s[HLFSR_W-2])};
  endfunction

endpackage

// File: rtl/tia_biphase_clock.sv
// Divide-by-four phase generator: registered hphi1/hphi2 strobes and the latched reset rsynl.
module tia_biphase_clock
  import tia_pkg::*;
(
  input  logic clk,
  input  logic rsyn,
  output logic hphi1,
  output logic hphi2,
  output logic rsynl,
  output logic phi2_entry
);

  logic [PHASE_W-1:0] p_q, p_d;
  logic hphi1_q, hphi1_d;
  logic hphi2_q, hphi2_d;
  logic rsynl_q, rsynl_d;

  always_comb begin
    p_d = (p_q == PHASE_RESET) ? PHASE_PHI1 : p_q + 1'b1;
    hphi1_d = (p_d == PHASE_PHI1);
    hphi2_d = (p_d == PHASE_PHI2);
    rsynl_d = hphi1_d ? 1'b0 : rsynl_q;
    phi2_entry = hphi2_d;
  end

  always_ff @(posedge clk or posedge rsyn) begin
    if (rsyn) begin
      p_q     <= PHASE_RESET;
      hphi1_q <= 1'b0;
      hphi2_q <= 1'b0;
      rsynl_q <= 1'b1;
    end else begin
      p_q     <= p_d;
      hphi1_q <= hphi1_d;
      hphi2_q <= hphi2_d;
      rsynl_q <= rsynl_d;
    end
  end

  assign hphi1 = hphi1_q;
  assign hphi2 = hphi2_q;
  assign rsynl = rsynl_q;

endmodule

// File: rtl/tia_horizontal_timebase.sv
// TIA horizontal timebase: phase strobes, 57-state H-sync LFSR, shb decode and rsynd.
// Define TIA_HTIMEBASE_ASSERT_EN to compile in simulation assertions.
module tia_horizontal_timebase
  import tia_pkg::*;
(
  input  logic       clk,
  input  logic       rsyn,
  output logic       hphi1,
  output logic       hphi2,
  output logic       rsynl,
  output logic [5:0] out,
  output logic       shb,
  output logic       rsynd
);

  logic phi2_entry;
  logic [HLFSR_W-1:0] out_q, out_d;
  logic rsynd_q, rsynd_d;

  tia_biphase_clock u_biphase (
    .clk        (clk),
    .rsyn       (rsyn),
    .hphi1      (hphi1),
    .hphi2      (hphi2),
    .rsynl      (rsynl),
    .phi2_entry (phi2_entry)
  );

  // The shift happens on the edge that leaves phi2, so hphi2 high acts as the enable.
  always_comb begin
    shb     = (out_q == HLFSR_TERMINAL) | rsynl;
    out_d   = out_q;
    if (hphi2) begin
      out_d = shb ? HLFSR_RESET : hlfsr_next(out_q);
    end
    rsynd_d = phi2_entry ? 1'b0 : rsynd_q;
  end

  always_ff @(posedge clk or posedge rsyn) begin
    if (rsyn) begin
      out_q   <= HLFSR_RESET;
      rsynd_q <= 1'b1;
    end else begin
      out_q   <= out_d;
      rsynd_q <= rsynd_d;
    end
  end

  assign out   = out_q;
  assign rsynd = rsynd_q;

`ifdef TIA_HTIMEBASE_ASSERT_EN
  int unsigned shift_cnt_q;

  always_ff @(posedge clk or posedge rsyn) begin
    if (rsyn) begin
      shift_cnt_q <= 0;
    end else begin
      a_no_overlap: assert (!(hphi1 && hphi2));
      a_no_ones:    assert (out_q != '1);
      if (hphi2) begin
        if (out_q == HLFSR_RESET) begin
          shift_cnt_q <= 1;
        end else begin
          shift_cnt_q <= shift_cnt_q + 1;
          if (out_d == HLFSR_RESET) begin
            a_period: assert (shift_cnt_q + 1 == HLFSR_PERIOD);
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_tia_horizontal_timebase.sv
// Directed, table-driven bench for tia_horizontal_timebase.
module tb_tia_horizontal_timebase;

  logic       clk = 1'b0;
  logic       rsyn = 1'b1;
  logic       hphi1, hphi2, rsynl, shb, rsynd;
  logic [5:0] out;

  int n_pass  = 0;
  int n_total = 0;

  logic [5:0] hout [0:127];
  logic       hshb [0:127];

  typedef struct {
    int         idx;
    logic [5:0] exp_out;
    logic       exp_shb;
  } vec_t;

  vec_t vecs [12];

  tia_horizontal_timebase dut (
    .clk   (clk),
    .rsyn  (rsyn),
    .hphi1 (hphi1),
    .hphi2 (hphi2),
    .rsynl (rsynl),
    .out   (out),
    .shb   (shb),
    .rsynd (rsynd)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic next_hphi1(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (hphi1) found = 1'b1;
    end
    check({name, "_found"}, 32'(found), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hphi1"}, 32'(hphi1), 32'd0);
    check({tag, "_hphi2"}, 32'(hphi2), 32'd0);
    check({tag, "_out"},   32'(out),   32'd0);
    check({tag, "_rsynl"}, 32'(rsynl), 32'd1);
    check({tag, "_rsynd"}, 32'(rsynd), 32'd1);
    check({tag, "_shb"},   32'(shb),   32'd1);
  endtask

  initial begin
    int k;

    vecs[0]  = '{0,   6'b000000, 1'b0};
    vecs[1]  = '{1,   6'b000001, 1'b0};
    vecs[2]  = '{2,   6'b000011, 1'b0};
    vecs[3]  = '{3,   6'b000111, 1'b0};
    vecs[4]  = '{4,   6'b001111, 1'b0};
    vecs[5]  = '{5,   6'b011111, 1'b0};
    vecs[6]  = '{6,   6'b111110, 1'b0};
    vecs[7]  = '{30,  6'b101110, 1'b0};
    vecs[8]  = '{56,  6'b001010, 1'b1};
    vecs[9]  = '{57,  6'b000000, 1'b0};
    vecs[10] = '{58,  6'b000001, 1'b0};
    vecs[11] = '{113, 6'b001010, 1'b1};

    rsyn = 1'b1;
    repeat (3) tick();
    check_reset_vals("held_reset");

    @(negedge clk);
    rsyn = 1'b0;
    k = 0;
    for (int c = 1; c <= 4 * 115; c++) begin
      tick();
      if (c <= 40) begin
        check("phase_hphi1", 32'(hphi1), 32'(((c - 1) % 4) == 0));
        check("phase_hphi2", 32'(hphi2), 32'(((c - 1) % 4) == 2));
        check("phase_overlap", 32'(hphi1 & hphi2), 32'd0);
      end
      if (c == 1) begin
        check("edge1_rsynl", 32'(rsynl), 32'd0);
        check("edge1_rsynd", 32'(rsynd), 32'd1);
        check("edge1_out",   32'(out),   32'd0);
      end
      if (c == 2) check("edge2_rsynd", 32'(rsynd), 32'd1);
      if (c == 3) check("edge3_rsynd", 32'(rsynd), 32'd0);
      if (c == 4) check("edge4_out",   32'(out),   32'd1);
      if (hphi1 && k < 128) begin
        hout[k] = out;
        hshb[k] = shb;
        k++;
      end
    end
    check("hphi1_count", 32'(k), 32'd115);

    for (int i = 0; i < 12; i++) begin
      check($sformatf("seq_out_%0d", vecs[i].idx), 32'(hout[vecs[i].idx]), 32'(vecs[i].exp_out));
      check($sformatf("seq_shb_%0d", vecs[i].idx), 32'(hshb[vecs[i].idx]), 32'(vecs[i].exp_shb));
    end

    for (int j = 0; j < 115; j++) begin
      check($sformatf("zero_at_%0d", j), 32'(hout[j] == 6'd0), 32'((j % 57) == 0));
    end

    // Restart cleanly, then hit reset in the middle of hphi1 #30.
    @(negedge clk);
    rsyn = 1'b1;
    #1;
    check_reset_vals("async_reset");
    tick();
    @(negedge clk);
    rsyn = 1'b0;
    next_hphi1("restart0");
    check("restart0_out", 32'(out), 32'd0);
    repeat (30) next_hphi1("to_h30");
    check("h30_out", 32'(out), 32'b101110);
    check("h30_hphi1", 32'(hphi1), 32'd1);
    rsyn = 1'b1;
    #1;
    check_reset_vals("midline");
    repeat (5) tick();
    check_reset_vals("frozen");

    @(negedge clk);
    rsyn = 1'b0;
    next_hphi1("post0");
    check("post0_out", 32'(out), 32'd0);
    for (int j = 1; j <= 57; j++) begin
      next_hphi1("post");
      if (j == 1) check("post1_out", 32'(out), 32'd1);
      if (j < 57) check($sformatf("post_nonzero_%0d", j), 32'(out != 6'd0), 32'd1);
      else        check("post57_zero", 32'(out), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
